tt_um_dff_mem_host: RTL

Built-in self-test initiator for the team's 16-byte DFF memory tile.
- Drives the memory's pin interface: address, ce_n and lr_n on uo_out, data on the bidirectional uio bus.
- Fills the memory with a selectable pattern, turns the bus around, reads every byte back and compares it.
- Reports done, pass/fail and the first failing address.
- Wiring: uo_out connects directly to the memory's ui_in; uio connects pin-to-pin with the memory's uio.

---
 rtl/tt_um_dff_mem_host_if.sv | 20 ++
 rtl/tt_um_dff_mem_host.sv | 127 ++++++++++++
 2 files changed

// File: rtl/tt_um_dff_mem_host_if.sv
// Pin bundle between the BIST host and the DFF memory tile (TinyTapeout pin names).
// master = host side driving address/control and write data; slave = memory/environment side.
interface tt_um_dff_mem_host_if;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic       ena;

  modport master (
    input  ui_in, uio_in, ena,
    output uo_out, uio_out, uio_oe
  );

  modport slave (
    output ui_in, uio_in, ena,
    input  uo_out, uio_out, uio_oe
  );
endinterface

// File: rtl/tt_um_dff_mem_host.sv
// BIST host for the DFF memory tile: pattern fill, bus turnaround, read-back compare, status report.
// Start to done is 2N+1 edges (N+1 read-only); no backpressure, the memory answers within the cycle.
module tt_um_dff_mem_host #(
  parameter int RAM_BYTES = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  tt_um_dff_mem_host_if.master bus
);
  localparam int ADDR_BITS = $clog2(RAM_BYTES);
  localparam logic [ADDR_BITS-1:0] K_LAST = ADDR_BITS'(RAM_BYTES - 1);

  typedef enum logic [2:0] {IDLE, WRITE, TURN, READ, DONE} state_t;

  state_t               state_q, state_d;
  logic [ADDR_BITS-1:0] k_q, k_d;
  logic [1:0]           pat_q, pat_d;
  logic                 ro_q, ro_d;
  logic                 fail_q, fail_d;
  logic [ADDR_BITS-1:0] fail_addr_q, fail_addr_d;
  logic                 start_prev_q;
  logic                 start;
  logic [7:0]           uo_q, uo_d;
  logic [7:0]           uio_out_q, uio_out_d;
  logic [7:0]           uio_oe_q, uio_oe_d;
  logic                 unused_ok;

  assign unused_ok = &{1'b0, bus.ena, bus.ui_in[7:4]};
  assign start     = bus.ui_in[0] & ~start_prev_q;

  function automatic logic [7:0] exp_byte(input logic [1:0] pat, input logic [ADDR_BITS-1:0] a);
    logic [3:0] a4;
    a4 = 4'(a);
    case (pat)
      2'b00:   return 8'h00;
      2'b01:   return 8'hFF;
      2'b10:   return a4[0] ? 8'hAA : 8'h55;
      default: return {a4, ~a4};
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    pat_d       = pat_q;
    ro_d        = ro_q;
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          pat_d       = bus.ui_in[2:1];
          ro_d        = bus.ui_in[3];
          fail_d      = 1'b0;
          fail_addr_d = '0;
          k_d         = '0;
          state_d     = bus.ui_in[3] ? TURN : WRITE;
        end
      end
      WRITE: begin
        k_d = k_q + 1'b1;
        if (k_q == K_LAST) state_d = TURN;
      end
      TURN: begin
        k_d     = '0;
        state_d = READ;
      end
      READ: begin
        // fail_addr only captures the first miscompare; fail itself is sticky
        if (bus.uio_in != exp_byte(pat_q, k_q)) begin
          fail_d = 1'b1;
          if (!fail_q) fail_addr_d = k_q;
        end
        k_d = k_q + 1'b1;
        if (k_q == K_LAST) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from next state so the pins are clean flop outputs.
  always_comb begin
    uo_d      = {2'b11, fail_d, 5'b0_0000};
    uio_out_d = 8'h00;
    uio_oe_d  = 8'h00;
    case (state_d)
      WRITE: begin
        uo_d      = {2'b01, fail_d, 1'b0, 4'(k_d)};
        uio_out_d = exp_byte(pat_d, k_d);
        uio_oe_d  = 8'hFF;
      end
      READ:    uo_d = {2'b10, fail_d, 1'b0, 4'(k_d)};
      DONE:    uo_d = {2'b11, fail_d, 1'b1, 4'(fail_addr_d)};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      k_q          <= '0;
      pat_q        <= 2'b00;
      ro_q         <= 1'b0;
      fail_q       <= 1'b0;
      fail_addr_q  <= '0;
      start_prev_q <= 1'b0;
      uo_q         <= 8'hC0;
      uio_out_q    <= 8'h00;
      uio_oe_q     <= 8'h00;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      pat_q        <= pat_d;
      ro_q         <= ro_d;
      fail_q       <= fail_d;
      fail_addr_q  <= fail_addr_d;
      start_prev_q <= bus.ui_in[0];
      uo_q         <= uo_d;
      uio_out_q    <= uio_out_d;
      uio_oe_q     <= uio_oe_d;
    end
  end

  assign bus.uo_out  = uo_q;
  assign bus.uio_out = uio_out_q;
  assign bus.uio_oe  = uio_oe_q;
endmodule
